// File: rtl/vfpu_store_sched.sv
// rtl/vfpu_store_sched.sv - store-job scheduler: command FIFO, sink start/done sequencing, job counter, watchdog
module vfpu_store_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  sink_req_start_o,
    output logic [ADDR_WIDTH-1:0] sink_base_addr_o,
    output logic [LEN_WIDTH-1:0]  sink_trans_size_o,
    output logic [LEN_WIDTH-1:0]  sink_line_stride_o,
    output logic [LEN_WIDTH-1:0]  sink_line_length_o,
    output logic [LEN_WIDTH-1:0]  sink_feat_stride_o,
    output logic [LEN_WIDTH-1:0]  sink_feat_length_o,
    input  logic                  sink_ready_start_i,
    input  logic                  sink_done_i,
    output logic                  busy_o,
    output logic                  evt_o,
    output logic [LEN_WIDTH-1:0]  jobs_done_o,
    output logic                  timeout_o
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fifo_addr [CMD_DEPTH];
    logic [LEN_WIDTH-1:0]  fifo_len  [CMD_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fill;
    logic                  full, empty, push, pop, launch, skip, wd_expire;
    logic [31:0]           wd_q;
    logic                  skip_evt_q, started_q, timeout_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q, jobs_q;

    assign full  = (fill == (PW+1)'(CMD_DEPTH));
    assign empty = (fill == '0);
    assign push  = cmd_valid_i && !full;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        launch    = 1'b0;
        skip      = 1'b0;
        wd_expire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    // zero-length jobs retire without touching the sink
                    if (fifo_len[rd_ptr] == '0) begin
                        pop  = 1'b1;
                        skip = 1'b1;
                    end else if (sink_ready_start_i) begin
                        pop     = 1'b1;
                        launch  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = RUN;
            RUN: begin
                if (sink_done_i) begin
                    state_d = DONE;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cmd_addr_i;
            fifo_len[wr_ptr]  <= cmd_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            wd_q       <= '0;
            skip_evt_q <= 1'b0;
            started_q  <= 1'b0;
            timeout_q  <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            jobs_q     <= '0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            wd_q       <= '0;
            skip_evt_q <= 1'b0;
            started_q  <= 1'b0;
            timeout_q  <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            jobs_q     <= '0;
        end else begin
            state_q    <= state_d;
            skip_evt_q <= skip;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fill <= fill + 1'b1;
            else if (pop && !push) fill <= fill - 1'b1;
            if (skip || state_q == DONE) jobs_q <= jobs_q + 1'b1;
            if (wd_expire) timeout_q <= 1'b1;
            if (state_q == ISSUE)    wd_q <= '0;
            else if (state_q == RUN) wd_q <= wd_q + 1'b1;
            if (launch) begin
                base_q    <= fifo_addr[rd_ptr];
                len_q     <= fifo_len[rd_ptr];
                started_q <= 1'b1;
            end
        end
    end

    // constant addressgen fields read as zero until the first job is launched
    assign cmd_ready_o        = !full;
    assign sink_req_start_o   = (state_q == ISSUE);
    assign sink_base_addr_o   = base_q;
    assign sink_trans_size_o  = len_q;
    assign sink_line_length_o = len_q;
    assign sink_line_stride_o = started_q ? LEN_WIDTH'(4) : '0;
    assign sink_feat_length_o = started_q ? LEN_WIDTH'(1) : '0;
    assign sink_feat_stride_o = '0;
    assign busy_o             = (state_q != IDLE) || !empty;
    assign evt_o              = skip_evt_q || (state_q == DONE);
    assign jobs_done_o        = jobs_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_vfpu_store_sched.sv
// tb/tb_vfpu_store_sched.sv - self-checking bench for vfpu_store_sched
module tb_vfpu_store_sched;

    localparam int TO = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        req_start;
    logic [31:0] base_addr;
    logic [15:0] trans_size, line_stride, line_length, feat_stride, feat_length;
    logic        ready_start = 1'b0;
    logic        sink_done = 1'b0;
    logic        busy, evt, timeout;
    logic [15:0] jobs_done;

    vfpu_store_sched #(
        .ADDR_WIDTH(32), .LEN_WIDTH(16), .CMD_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .sink_req_start_o(req_start), .sink_base_addr_o(base_addr),
        .sink_trans_size_o(trans_size), .sink_line_stride_o(line_stride),
        .sink_line_length_o(line_length), .sink_feat_stride_o(feat_stride),
        .sink_feat_length_o(feat_length), .sink_ready_start_i(ready_start),
        .sink_done_i(sink_done), .busy_o(busy), .evt_o(evt),
        .jobs_done_o(jobs_done), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
    } job_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          dly;
    } vec_t;

    int   checks = 0;
    int   passed = 0;
    int   req_cnt = 0;
    int   evt_cnt = 0;
    int   cnt_model = 0;
    job_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // scoreboard: every start request must match the oldest outstanding non-empty command
    always @(negedge clk) begin
        if (!rst && evt) evt_cnt++;
        if (!rst && req_start) begin
            req_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_req: req_start=1 with empty scoreboard, required 0");
            end else begin
                job_t j;
                j = exp_q.pop_front();
                chk("req_base", base_addr, j.addr);
                chk("req_trans_size", trans_size, j.len);
                chk("req_line_length", line_length, j.len);
                chk("req_line_stride", line_stride, 4);
                chk("req_feat_stride", feat_stride, 0);
                chk("req_feat_length", feat_length, 1);
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [15:0] l, output bit acc);
        job_t j;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        acc       = cmd_ready;
        if (acc && l != 0) begin
            j.addr = a;
            j.len  = l;
            exp_q.push_back(j);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!req_start && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (req_start) passed++;
        else $display("FAIL %s: req_start=0 after 20 cycles, required 1", nm);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [15:0] l, input int dly);
        bit acc;
        int c0;
        c0 = cnt_model;
        push(a, l, acc);
        chk("job_accept", acc, 1);
        if (l == 0) begin
            chk("skip_evt_t1", evt, 0);
            step();
            chk("skip_evt", evt, 1);
            chk("skip_cnt", jobs_done, c0 + 1);
            chk("skip_no_req", req_start, 0);
            step();
            chk("skip_evt_end", evt, 0);
        end else begin
            chk("lat_t1", req_start, 0);
            step();
            chk("lat_t2", req_start, 1);
            step();
            repeat (dly) step();
            sink_done = 1'b1;
            step();
            sink_done = 1'b0;
            chk("done_evt", evt, 1);
            chk("done_cnt_hold", jobs_done, c0);
            step();
            chk("done_cnt", jobs_done, c0 + 1);
            chk("done_evt_end", evt, 0);
            chk("done_idle", busy, 0);
        end
        cnt_model++;
    endtask

    initial begin
        vec_t vecs[5];
        bit   acc;
        int   e0, r0;

        vecs[0] = '{addr: 32'h0000_1000, len: 16'd16,     dly: 0};
        vecs[1] = '{addr: 32'h0000_0000, len: 16'd0,      dly: 0};
        vecs[2] = '{addr: 32'h0000_2000, len: 16'd8,      dly: 3};
        vecs[3] = '{addr: 32'hFFFF_FFFC, len: 16'hFFFF,   dly: 5};
        vecs[4] = '{addr: 32'h0000_0040, len: 16'd1,      dly: 1};

        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", req_start, 0);
        chk("rst_base", base_addr, 0);
        chk("rst_stride", line_stride, 0);
        chk("rst_count", jobs_done, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        ready_start = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_job(vecs[i].addr, vecs[i].len, vecs[i].dly);

        // FIFO fill with the sink not ready: the extra command must be refused
        ready_start = 1'b0;
        r0 = req_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            push(32'h100 * (i + 1), 16'(i + 2), acc);
            chk("fill_accept", acc, (i < DEPTH) ? 1 : 0);
        end
        chk("fill_ready_low", cmd_ready, 0);
        chk("fill_busy", busy, 1);
        chk("fill_no_req", req_cnt, r0);
        ready_start = 1'b1;
        e0 = evt_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            wait_req("drain_req");
            step();
            sink_done = 1'b1;
            step();
            sink_done = 1'b0;
            step();
        end
        step();
        chk("drain_scoreboard", exp_q.size(), 0);
        chk("drain_evts", evt_cnt - e0, DEPTH);
        cnt_model += DEPTH;
        chk("drain_cnt", jobs_done, cnt_model);
        chk("drain_idle", busy, 0);

        // watchdog: sink never reports done
        push(32'h3000, 16'd4, acc);
        wait_req("wd_req");
        e0 = evt_cnt;
        repeat (TO) step();
        chk("wd_before", timeout, 0);
        chk("wd_busy_before", busy, 1);
        step();
        chk("wd_flag", timeout, 1);
        chk("wd_idle", busy, 0);
        sink_done = 1'b1;
        step();
        sink_done = 1'b0;
        step();
        chk("wd_cnt", jobs_done, cnt_model);
        chk("wd_no_evt", evt_cnt - e0, 0);
        chk("wd_sticky", timeout, 1);

        // asynchronous reset in RUN with two commands queued
        ready_start = 1'b0;
        push(32'h4000, 16'd2, acc);
        push(32'h5000, 16'd3, acc);
        push(32'h6000, 16'd4, acc);
        ready_start = 1'b1;
        wait_req("rst_run_req");
        step();
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_base", base_addr, 0);
        chk("arst_len", trans_size, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_count", jobs_done, 0);
        exp_q.delete();
        cnt_model = 0;
        step();
        rst = 1'b0;
        r0 = req_cnt;
        repeat (10) step();
        chk("arst_no_req", req_cnt, r0);
        chk("arst_idle", busy, 0);

        // clear in the same cycle as done
        run_job(32'h7000, 16'd5, 0);
        push(32'h8000, 16'd6, acc);
        chk("clr_lat_t1", req_start, 0);
        step();
        chk("clr_lat_t2", req_start, 1);
        step();
        push(32'h9000, 16'd7, acc);
        e0 = evt_cnt;
        sink_done = 1'b1;
        clear = 1'b1;
        step();
        sink_done = 1'b0;
        clear = 1'b0;
        chk("clr_evt", evt, 0);
        chk("clr_count", jobs_done, 0);
        chk("clr_busy", busy, 0);
        chk("clr_ready", cmd_ready, 1);
        chk("clr_base", base_addr, 0);
        chk("clr_feat_len", feat_length, 0);
        exp_q.delete();
        r0 = req_cnt;
        repeat (10) step();
        chk("clr_no_req", req_cnt, r0);
        chk("clr_no_evt", evt_cnt - e0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
